hc_csr_bank: RTL

- Parametrised MMIO control/status register bank for HardCloud AFUs.
- Sits between the CCI-P c0 Rx MMIO stream and the application datapath.
- Decodes host writes to the DSM base, control and a table of NUM_BUFFERS buffer descriptors, and answers host MMIO reads on c2.
- Runs the application control state machine and a run-cycle counter.

---
 rtl/hc_csr_bank_pkg.sv | 37 +++
 rtl/hc_csr_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_csr_bank_pkg.sv
// CCI-P MMIO channel payloads used by the HardCloud CSR bank.
package hc_csr_bank_pkg;

    localparam int unsigned MMIO_ADDR_W = 16;
    localparam int unsigned TID_W       = 9;
    localparam int unsigned CL_DATA_W   = 512;
    localparam int unsigned MMIO_DATA_W = 64;

    // MMIO request header carried on c0 Rx (address is in 32-bit words)
    typedef struct packed {
        logic [MMIO_ADDR_W-1:0] address;
        logic [1:0]             length;
        logic                   rsvd;
        logic [TID_W-1:0]       tid;
    } t_ccip_c0_ReqMmioHdr;

    // c0 Rx: host MMIO read/write requests
    typedef struct packed {
        t_ccip_c0_ReqMmioHdr    hdr;
        logic                   mmioRdValid;
        logic                   mmioWrValid;
        logic [CL_DATA_W-1:0]   data;
    } t_if_ccip_c0_Rx;

    // MMIO read response header
    typedef struct packed {
        logic [TID_W-1:0]       tid;
    } t_ccip_c2_RspMmioHdr;

    // c2 Tx: MMIO read responses
    typedef struct packed {
        t_ccip_c2_RspMmioHdr    hdr;
        logic                   mmioRdValid;
        logic [MMIO_DATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

endpackage

// File: rtl/hc_csr_bank.sv
// MMIO control/status register bank: decodes host MMIO accesses, holds the
// DSM base and buffer descriptor table, and runs the application control FSM.
module hc_csr_bank
    import hc_csr_bank_pkg::*;
#(
    parameter int unsigned NUM_BUFFERS = 2,
    parameter logic [15:0] BUF_BASE    = 16'h120,
    parameter logic [63:0] DFH_VALUE   = 64'h1000_0100_0000_0000,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  t_if_ccip_c0_Rx              rx_c0,
    output t_if_ccip_c2_Tx              tx_c2,
    input  logic                        app_done,
    output logic                        app_reset,
    output logic                        app_start,
    output logic                        running,
    output logic [63:0]                 dsm_base,
    output logic [NUM_BUFFERS*42-1:0]   buf_addr,
    output logic [NUM_BUFFERS*32-1:0]   buf_size,
    output logic [NUM_BUFFERS-1:0]      buf_valid
);

    localparam int unsigned OFF_W     = MMIO_ADDR_W + 2;
    localparam int unsigned WIN_IDX_W = OFF_W - 4;
    localparam int unsigned ADDR_W    = 42;
    localparam int unsigned SIZE_W    = 32;
    localparam int unsigned CTRL_W    = 32;
    localparam int unsigned CNT_W     = 64;
    localparam int unsigned DONE_W    = 16;

    localparam logic [OFF_W-1:0] OFF_DFH        = 18'h000;
    localparam logic [OFF_W-1:0] OFF_AFU_ID_L   = 18'h008;
    localparam logic [OFF_W-1:0] OFF_AFU_ID_H   = 18'h010;
    localparam logic [OFF_W-1:0] OFF_RUN_CYCLES = 18'h100;
    localparam logic [OFF_W-1:0] OFF_STATUS     = 18'h108;
    localparam logic [OFF_W-1:0] OFF_DSM_BASE   = 18'h110;
    localparam logic [OFF_W-1:0] OFF_CONTROL    = 18'h118;

    localparam logic [CTRL_W-1:0] CMD_ASSERT_RST   = 32'h0;
    localparam logic [CTRL_W-1:0] CMD_DEASSERT_RST = 32'h1;
    localparam logic [CTRL_W-1:0] CMD_START        = 32'h3;
    localparam logic [CTRL_W-1:0] CMD_STOP         = 32'h7;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_next;
    logic                   app_reset_d;
    logic                   app_start_d;
    logic                   running_d;

    logic [CTRL_W-1:0]      control_q;
    logic [CNT_W-1:0]       run_cycles_q;
    logic [DONE_W-1:0]      done_count_q;

    logic [ADDR_W-1:0]      addr_q [NUM_BUFFERS];
    logic [SIZE_W-1:0]      size_q [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0] addr_seen_q;
    logic [NUM_BUFFERS-1:0] size_seen_q;
    logic [NUM_BUFFERS-1:0] valid_q;

    // Request decode shared by the read and write paths
    logic [OFF_W-1:0]       off;
    logic [OFF_W-1:0]       win_off;
    logic [WIN_IDX_W-1:0]   win_idx;
    logic                   aligned;
    logic                   in_win;
    logic                   locked;
    logic [63:0]            wdata;
    logic [CTRL_W-1:0]      cmd;
    logic                   ctrl_wr;
    logic                   dsm_wr;
    logic                   desc_wr;
    logic                   assert_rst;
    logic                   done_hit;
    logic [63:0]            rd_data;

    assign off        = {rx_c0.hdr.address, 2'b00};
    assign win_off    = off - OFF_W'(BUF_BASE);
    assign win_idx    = win_off[OFF_W-1:4];
    assign aligned    = (off[2:0] == 3'b000);
    assign in_win     = aligned && (off >= OFF_W'(BUF_BASE)) &&
                        (win_idx < WIN_IDX_W'(NUM_BUFFERS));
    assign locked     = (state_q == S_RUN);
    assign wdata      = rx_c0.data[63:0];
    assign cmd        = wdata[CTRL_W-1:0];
    assign ctrl_wr    = rx_c0.mmioWrValid && (off == OFF_CONTROL);
    assign dsm_wr     = rx_c0.mmioWrValid && (off == OFF_DSM_BASE) && !locked;
    assign desc_wr    = rx_c0.mmioWrValid && in_win && !locked;
    assign assert_rst = ctrl_wr && (cmd == CMD_ASSERT_RST);
    // A CONTROL write in the same cycle takes precedence over app_done
    assign done_hit   = app_done && !ctrl_wr && (state_q == S_RUN);

    // FSM state register; outputs are registered from the next-state decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RESET;
            app_reset <= 1'b1;
            app_start <= 1'b0;
            running   <= 1'b0;
        end else begin
            state_q   <= state_next;
            app_reset <= app_reset_d;
            app_start <= app_start_d;
            running   <= running_d;
        end
    end

    // FSM next state from CONTROL commands and app_done
    always_comb begin
        state_next = state_q;
        if (ctrl_wr) begin
            case (cmd)
                CMD_ASSERT_RST: begin
                    state_next = S_RESET;
                end
                CMD_DEASSERT_RST: begin
                    if (state_q == S_RESET) state_next = S_IDLE;
                end
                CMD_START: begin
                    if (state_q == S_IDLE || state_q == S_DONE) state_next = S_RUN;
                end
                CMD_STOP: begin
                    if (state_q == S_RUN || state_q == S_DONE) state_next = S_IDLE;
                end
                default: begin
                    state_next = state_q;
                end
            endcase
        end else if (done_hit) begin
            state_next = S_DONE;
        end
    end

    // FSM output decode; app_start marks entry into S_RUN
    always_comb begin
        app_reset_d = 1'b0;
        app_start_d = 1'b0;
        running_d   = 1'b0;
        if (state_next == S_RESET) app_reset_d = 1'b1;
        if (state_next == S_RUN)   running_d   = 1'b1;
        if (state_next == S_RUN && state_q != S_RUN) app_start_d = 1'b1;
    end

    // Run-cycle counter (saturating) and completion counter (wrapping)
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles_q <= '0;
            done_count_q <= '0;
        end else begin
            if (app_start_d) begin
                run_cycles_q <= '0;
            end else if (state_q == S_RUN && run_cycles_q != '1) begin
                run_cycles_q <= run_cycles_q + CNT_W'(1);
            end
            if (assert_rst) begin
                done_count_q <= '0;
            end else if (done_hit) begin
                done_count_q <= done_count_q + DONE_W'(1);
            end
        end
    end

    // CONTROL and DSM base registers
    always_ff @(posedge clk) begin
        if (reset) begin
            control_q <= '0;
            dsm_base  <= '0;
        end else begin
            if (ctrl_wr) control_q <= cmd;
            if (dsm_wr)  dsm_base  <= wdata;
        end
    end

    // Descriptor table; a descriptor becomes valid once both halves are written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
                addr_q[i] <= '0;
                size_q[i] <= '0;
            end
            addr_seen_q <= '0;
            size_seen_q <= '0;
            valid_q     <= '0;
        end else if (assert_rst) begin
            addr_seen_q <= '0;
            size_seen_q <= '0;
            valid_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
                if (desc_wr && win_idx == WIN_IDX_W'(i)) begin
                    if (off[3]) begin
                        size_q[i]      <= wdata[SIZE_W-1:0];
                        size_seen_q[i] <= 1'b1;
                        valid_q[i]     <= addr_seen_q[i];
                    end else begin
                        addr_q[i]      <= wdata[ADDR_W-1:0];
                        addr_seen_q[i] <= 1'b1;
                        valid_q[i]     <= size_seen_q[i];
                    end
                end
            end
        end
    end

    // Flatten descriptor table onto the output buses
    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf_out
        assign buf_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
        assign buf_size[g*SIZE_W +: SIZE_W] = size_q[g];
    end
    assign buf_valid = valid_q;

    // Read data mux over current (pre-write) register contents
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_DFH:        rd_data = DFH_VALUE;
            OFF_AFU_ID_L:   rd_data = AFU_ID_L;
            OFF_AFU_ID_H:   rd_data = AFU_ID_H;
            OFF_RUN_CYCLES: rd_data = run_cycles_q;
            OFF_STATUS:     rd_data = {32'd0, done_count_q, 14'd0, state_q};
            OFF_DSM_BASE:   rd_data = dsm_base;
            OFF_CONTROL:    rd_data = 64'(control_q);
            default:        rd_data = '0;
        endcase
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
            if (in_win && win_idx == WIN_IDX_W'(i)) begin
                rd_data = off[3] ? 64'(size_q[i]) : 64'(addr_q[i]);
            end
        end
    end

    // Read response, one cycle after the request
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_c2 <= '0;
        end else begin
            tx_c2.mmioRdValid <= rx_c0.mmioRdValid;
            tx_c2.hdr.tid     <= rx_c0.hdr.tid;
            tx_c2.data        <= rd_data;
        end
    end

    // Request fields this block does not consume
    logic unused;
    assign unused = ^{rx_c0.hdr.length, rx_c0.hdr.rsvd,
                      rx_c0.data[CL_DATA_W-1:64], win_off[3:0]};

endmodule
